bpe_token_encoder: RTL and testbench

- Parametrised successor of the grouper-based encoder: repeatedly merges adjacent token pairs by vocabulary lookup, pass after pass, until a fixed point or a pass limit.
- Owns three synchronous single-port SRAM interfaces: vocab (read-only pair table) and two ping-pong token buffers A and B.
- Sits under the encoder top and replaces grouper plus matcher with one controller that reports result length, result buffer and pass count.

---
 rtl/bpe_token_encoder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_bpe_token_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpe_token_encoder.sv
// Iterative byte-pair merge controller: ping-pongs a token sequence between buffers A and B,
// replacing adjacent pairs found in the vocab table until no merge happens or the pass limit hits.
module bpe_token_encoder #(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned VOCAB_ADDR_WIDTH = 4,
  parameter int unsigned VOCAB_BASE       = 128,
  parameter int unsigned MAX_PASSES       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic [ADDR_WIDTH:0]           len_in,
  input  logic [VOCAB_ADDR_WIDTH:0]     vocab_count,
  output logic [VOCAB_ADDR_WIDTH-1:0]   vocab_addr,
  input  logic [2*DATA_WIDTH-1:0]       vocab_dout,
  output logic [ADDR_WIDTH-1:0]         buf_a_addr,
  output logic                          buf_a_we,
  output logic [DATA_WIDTH-1:0]         buf_a_din,
  input  logic [DATA_WIDTH-1:0]         buf_a_dout,
  output logic [ADDR_WIDTH-1:0]         buf_b_addr,
  output logic                          buf_b_we,
  output logic [DATA_WIDTH-1:0]         buf_b_din,
  input  logic [DATA_WIDTH-1:0]         buf_b_dout,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_WIDTH:0]           len_out,
  output logic                          result_sel,
  output logic [3:0]                    passes
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned VW = VOCAB_ADDR_WIDTH + 1;
  localparam int unsigned KW = VOCAB_ADDR_WIDTH;
  localparam int unsigned PW = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_L, RD_R, SCAN_ADDR, SCAN_CMP, EMIT, PASS_END, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   i_q, i_d;
  logic [LW-1:0]   w_q, w_d;
  logic [LW-1:0]   len_q, len_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   left_q, left_d;
  logic [DW-1:0]   right_q, right_d;
  logic            merged_q, merged_d;
  logic            src_b_q, src_b_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [3:0]      passes_q, passes_d;
  logic            sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic            a_we_q, a_we_d, b_we_q, b_we_d;
  logic [DW-1:0]   a_din_q, a_din_d, b_din_q, b_din_d;

  logic            emit;
  logic [DW-1:0]   emit_tok;
  logic            src_load;
  logic [AW-1:0]   src_addr;
  logic [DW-1:0]   src_dout;
  logic [DW-1:0]   merge_tok;

  assign src_dout  = src_b_q ? buf_b_dout : buf_a_dout;
  assign merge_tok = DW'(VOCAB_BASE) + DW'(k_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      w_q        <= '0;
      len_q      <= '0;
      vcnt_q     <= '0;
      k_q        <= '0;
      left_q     <= '0;
      right_q    <= '0;
      merged_q   <= 1'b0;
      src_b_q    <= 1'b0;
      pass_cnt_q <= '0;
      passes_q   <= '0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_we_q     <= 1'b0;
      b_we_q     <= 1'b0;
      a_din_q    <= '0;
      b_din_q    <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      w_q        <= w_d;
      len_q      <= len_d;
      vcnt_q     <= vcnt_d;
      k_q        <= k_d;
      left_q     <= left_d;
      right_q    <= right_d;
      merged_q   <= merged_d;
      src_b_q    <= src_b_d;
      pass_cnt_q <= pass_cnt_d;
      passes_q   <= passes_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_we_q     <= a_we_d;
      b_we_q     <= b_we_d;
      a_din_q    <= a_din_d;
      b_din_q    <= b_din_d;
    end
  end

  // Next-state logic; SRAM controls are registered, so each address is set one state ahead
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    w_d        = w_q;
    len_d      = len_q;
    vcnt_d     = vcnt_q;
    k_d        = k_q;
    left_d     = left_q;
    right_d    = right_q;
    merged_d   = merged_q;
    src_b_d    = src_b_q;
    pass_cnt_d = pass_cnt_q;
    passes_d   = passes_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_we_d     = 1'b0;
    b_we_d     = 1'b0;
    a_din_d    = a_din_q;
    b_din_d    = b_din_q;
    emit       = 1'b0;
    emit_tok   = '0;
    src_load   = 1'b0;
    src_addr   = '0;

    case (state_q)
      IDLE: begin
        if (cs) begin
          busy_d     = 1'b1;
          len_d      = len_in;
          vcnt_d     = vocab_count;
          pass_cnt_d = '0;
          passes_d   = '0;
          sel_d      = 1'b0;
          src_b_d    = 1'b0;
          i_d        = '0;
          w_d        = '0;
          merged_d   = 1'b0;
          src_load   = 1'b1;
          state_d    = RD_L;
        end
      end
      RD_L: begin
        if (len_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // s[i] is being read now; queue s[i+1] so it lands right behind it
          src_load = 1'b1;
          src_addr = AW'(i_q + LW'(1));
          state_d  = RD_R;
        end
      end
      RD_R: begin
        left_d = src_dout;
        if (i_q == len_q - LW'(1) || vcnt_q == '0) begin
          emit     = 1'b1;
          emit_tok = src_dout;
          i_d      = i_q + LW'(1);
          state_d  = EMIT;
        end else begin
          k_d     = '0;
          state_d = SCAN_ADDR;
        end
      end
      SCAN_ADDR: begin
        if (k_q == '0) right_d = src_dout;
        state_d = SCAN_CMP;
      end
      SCAN_CMP: begin
        if (vocab_dout == {left_q, right_q}) begin
          emit     = 1'b1;
          emit_tok = merge_tok;
          i_d      = i_q + LW'(2);
          merged_d = 1'b1;
          state_d  = EMIT;
        end else if (VW'({1'b0, k_q}) + VW'(1) < vcnt_q) begin
          k_d     = k_q + KW'(1);
          state_d = SCAN_ADDR;
        end else begin
          emit     = 1'b1;
          emit_tok = left_q;
          i_d      = i_q + LW'(1);
          state_d  = EMIT;
        end
      end
      EMIT: begin
        w_d = w_q + LW'(1);
        if (i_q < len_q) begin
          src_load = 1'b1;
          src_addr = AW'(i_q);
          state_d  = RD_L;
        end else begin
          state_d = PASS_END;
        end
      end
      PASS_END: begin
        len_d      = w_q;
        passes_d   = (passes_q == 4'd15) ? passes_q : passes_q + 4'd1;
        sel_d      = ~src_b_q;
        pass_cnt_d = pass_cnt_q + PW'(1);
        if (!merged_q || pass_cnt_q == PW'(MAX_PASSES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          src_b_d  = ~src_b_q;
          i_d      = '0;
          w_d      = '0;
          merged_d = 1'b0;
          src_load = 1'b1;
          state_d  = RD_L;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes always go to the buffer opposite the current source
    if (emit) begin
      if (src_b_q) begin
        a_we_d   = 1'b1;
        a_addr_d = AW'(w_q);
        a_din_d  = emit_tok;
      end else begin
        b_we_d   = 1'b1;
        b_addr_d = AW'(w_q);
        b_din_d  = emit_tok;
      end
    end
    if (src_load) begin
      if (src_b_d) b_addr_d = src_addr;
      else         a_addr_d = src_addr;
    end
  end

  assign vocab_addr = k_q;
  assign buf_a_addr = a_addr_q;
  assign buf_a_we   = a_we_q;
  assign buf_a_din  = a_din_q;
  assign buf_b_addr = b_addr_q;
  assign buf_b_we   = b_we_q;
  assign buf_b_din  = b_din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign len_out    = len_q;
  assign result_sel = sel_q;
  assign passes     = passes_q;

endmodule

// File: tb/tb_bpe_token_encoder.sv
// Bench for bpe_token_encoder: two instances (pass limit 8 and 1) with SRAM models and a
// reference merge model feeding an expected-result queue.
module tb_bpe_token_encoder;

  localparam int unsigned VB = 8;

  typedef struct packed {
    logic [4:0]   len;
    logic         sel;
    logic [3:0]   passes;
    logic [127:0] toks;
    logic [7:0]   wr_a;
    logic [7:0]   wr_b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_v [2];
  logic [4:0]  len_in;
  logic [4:0]  vocab_count;
  logic [3:0]  vocab_addr [2];
  logic [15:0] vocab_dout [2];
  logic [3:0]  a_addr [2];
  logic [3:0]  b_addr [2];
  logic        a_we [2];
  logic        b_we [2];
  logic [7:0]  a_din [2];
  logic [7:0]  b_din [2];
  logic [7:0]  a_dout [2];
  logic [7:0]  b_dout [2];
  logic        busy [2];
  logic        done [2];
  logic [4:0]  len_out [2];
  logic        result_sel [2];
  logic [3:0]  passes [2];

  logic [15:0]  vocab_mem [16];
  logic [7:0]   mem_a [2][16];
  logic [7:0]   mem_b [2][16];
  int           wr_a_cnt [2] = '{0, 0};
  int           wr_b_cnt [2] = '{0, 0};
  int           dual_cnt [2] = '{0, 0};
  int           snap_a, snap_b, snap_d;
  logic         ld_en;
  int           ld_g;
  logic [127:0] ld_vec;
  exp_t         sb [$];
  int           n_checks, n_errors;

  always #5 clk = ~clk;

  bpe_token_encoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VOCAB_ADDR_WIDTH(4),
                      .VOCAB_BASE(VB), .MAX_PASSES(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .len_in(len_in), .vocab_count(vocab_count),
    .vocab_addr(vocab_addr[0]), .vocab_dout(vocab_dout[0]),
    .buf_a_addr(a_addr[0]), .buf_a_we(a_we[0]), .buf_a_din(a_din[0]), .buf_a_dout(a_dout[0]),
    .buf_b_addr(b_addr[0]), .buf_b_we(b_we[0]), .buf_b_din(b_din[0]), .buf_b_dout(b_dout[0]),
    .busy(busy[0]), .done(done[0]), .len_out(len_out[0]), .result_sel(result_sel[0]),
    .passes(passes[0]));

  bpe_token_encoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VOCAB_ADDR_WIDTH(4),
                      .VOCAB_BASE(VB), .MAX_PASSES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .len_in(len_in), .vocab_count(vocab_count),
    .vocab_addr(vocab_addr[1]), .vocab_dout(vocab_dout[1]),
    .buf_a_addr(a_addr[1]), .buf_a_we(a_we[1]), .buf_a_din(a_din[1]), .buf_a_dout(a_dout[1]),
    .buf_b_addr(b_addr[1]), .buf_b_we(b_we[1]), .buf_b_din(b_din[1]), .buf_b_dout(b_dout[1]),
    .busy(busy[1]), .done(done[1]), .len_out(len_out[1]), .result_sel(result_sel[1]),
    .passes(passes[1]));

  // Synchronous single-port SRAM models with write/overlap counters
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      vocab_dout[g] <= vocab_mem[vocab_addr[g]];
      a_dout[g]     <= mem_a[g][a_addr[g]];
      b_dout[g]     <= mem_b[g][b_addr[g]];
      if (a_we[g]) begin
        mem_a[g][a_addr[g]] <= a_din[g];
        wr_a_cnt[g]         <= wr_a_cnt[g] + 1;
      end
      if (b_we[g]) begin
        mem_b[g][b_addr[g]] <= b_din[g];
        wr_b_cnt[g]         <= wr_b_cnt[g] + 1;
      end
      if (a_we[g] && b_we[g]) dual_cnt[g] <= dual_cnt[g] + 1;
      if (ld_en && ld_g == g)
        for (int j = 0; j < 16; j++) mem_a[g][j] <= ld_vec[j*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [127:0] seq, input int n, input int vc, input int maxp);
    exp_t       e;
    logic [7:0] cur [16];
    logic [7:0] nxt [16];
    int         len, w, i, p;
    bit         merged, hit;
    e = '0;
    for (int j = 0; j < 16; j++) begin
      cur[j] = seq[j*8 +: 8];
      nxt[j] = 8'h00;
    end
    len = n;
    p   = 0;
    if (n > 0) begin
      do begin
        w = 0; i = 0; merged = 0;
        while (i < len) begin
          hit = 0;
          if (i + 1 < len)
            for (int k = 0; k < vc; k++)
              if (!hit && vocab_mem[k] == {cur[i], cur[i+1]}) begin
                nxt[w] = 8'(VB + k);
                hit    = 1;
              end
          if (hit) begin
            i += 2;
            merged = 1;
          end else begin
            nxt[w] = cur[i];
            i += 1;
          end
          w++;
        end
        if (p % 2 == 0) e.wr_b += 8'(w);
        else            e.wr_a += 8'(w);
        cur = nxt;
        len = w;
        p++;
      end while (merged && p < maxp);
    end
    e.len    = 5'(len);
    e.sel    = (p % 2 == 1);
    e.passes = 4'((p > 15) ? 15 : p);
    for (int j = 0; j < 16; j++)
      if (j < len) e.toks[j*8 +: 8] = cur[j];
    return e;
  endfunction

  function automatic logic [127:0] outs(input int g);
    return 128'({busy[g], done[g], a_we[g], b_we[g], len_out[g], result_sel[g], passes[g],
                 vocab_addr[g], a_addr[g], b_addr[g], a_din[g], b_din[g]});
  endfunction

  task automatic start_run(input int g, input logic [127:0] seq, input int n, input int vc,
                           input int maxp);
    ld_g   = g;
    ld_vec = seq;
    ld_en  = 1'b1;
    @(negedge clk);
    ld_en       = 1'b0;
    len_in      = 5'(n);
    vocab_count = 5'(vc);
    sb.push_back(model(seq, n, vc, maxp));
    snap_a = wr_a_cnt[g];
    snap_b = wr_b_cnt[g];
    snap_d = dual_cnt[g];
    cs_v[g] = 1'b1;
    @(negedge clk);
    cs_v[g] = 1'b0;
  endtask

  task automatic finish_run(input int g, input string tag, output int lat);
    exp_t         e;
    logic [127:0] got;
    int           c;
    c = 0;
    chk({tag, "_busy_run"}, 128'(busy[g]), 128'(1));
    while (done[g] !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    lat = c;
    e = sb.pop_front();
    if (done[g] !== 1'b1) begin
      chk({tag, "_done_timeout"}, 128'(done[g]), 128'(1));
      return;
    end
    chk({tag, "_len_out"}, 128'(len_out[g]), 128'(e.len));
    chk({tag, "_result_sel"}, 128'(result_sel[g]), 128'(e.sel));
    chk({tag, "_passes"}, 128'(passes[g]), 128'(e.passes));
    chk({tag, "_busy_done"}, 128'(busy[g]), 128'(0));
    got = '0;
    for (int j = 0; j < 16; j++)
      if (j < int'(e.len)) got[j*8 +: 8] = e.sel ? mem_b[g][j] : mem_a[g][j];
    chk({tag, "_tokens"}, got, e.toks);
    chk({tag, "_writes_a"}, 128'(wr_a_cnt[g] - snap_a), 128'(e.wr_a));
    chk({tag, "_writes_b"}, 128'(wr_b_cnt[g] - snap_b), 128'(e.wr_b));
    chk({tag, "_dual_we"}, 128'(dual_cnt[g] - snap_d), 128'(0));
  endtask

  initial begin
    int           lat, c, extra;
    exp_t         dropped;
    logic [127:0] seq;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; cs_v[0] = 1'b0; cs_v[1] = 1'b0;
    len_in = '0; vocab_count = '0;
    ld_en = 1'b0; ld_g = 0; ld_vec = '0;
    for (int k = 0; k < 16; k++) vocab_mem[k] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("reset_outs0", outs(0), '0);
    chk("reset_outs1", outs(1), '0);
    rst_n = 1'b1;
    @(negedge clk);

    vocab_mem[0] = 16'h0102;
    start_run(0, 128'h030201, 3, 1, 8);
    finish_run(0, "basic", lat);

    vocab_mem[1] = 16'h0803;
    start_run(0, 128'h030201, 3, 2, 8);
    finish_run(0, "nested", lat);

    vocab_mem[0] = 16'h0505;
    start_run(0, 128'h050505, 3, 1, 8);
    finish_run(0, "greedy", lat);

    vocab_mem[0] = 16'h0102;
    vocab_mem[1] = 16'h0102;
    start_run(0, 128'h0201, 2, 2, 8);
    finish_run(0, "priority", lat);

    start_run(0, 128'h0201, 0, 2, 8);
    finish_run(0, "len0", lat);
    chk("len0_latency", 128'(lat), 128'(1));

    start_run(0, 128'h07, 1, 2, 8);
    finish_run(0, "len1", lat);

    start_run(0, 128'h030201, 3, 0, 8);
    finish_run(0, "vc0", lat);

    vocab_mem[1] = 16'h0803;
    start_run(1, 128'h030201, 3, 2, 1);
    finish_run(1, "maxp1", lat);

    vocab_mem[0] = 16'h0102; vocab_mem[1] = 16'h0304; vocab_mem[2] = 16'h0809;
    vocab_mem[3] = 16'h0101; vocab_mem[4] = 16'h0A08; vocab_mem[5] = 16'h0203;
    seq = '0;
    for (int j = 0; j < 16; j++) seq[j*8 +: 8] = 8'($urandom_range(1, 4));
    start_run(0, seq, 16, 6, 8);
    finish_run(0, "long", lat);

    // Reset in the middle of pass 2, then a clean rerun
    for (int k = 2; k < 16; k++) vocab_mem[k] = 16'hFFFF;
    vocab_mem[0] = 16'h0102;
    vocab_mem[1] = 16'h0803;
    start_run(0, 128'h030201, 3, 2, 8);
    c = 0;
    while (passes[0] !== 4'd1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midreset_reach_pass2", 128'(passes[0]), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", outs(0), '0);
    dropped = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(0, 128'h030201, 3, 2, 8);
    finish_run(0, "after_reset", lat);

    // Start pulse while busy, with changed inputs, must be ignored
    vocab_mem[1] = 16'hFFFF;
    start_run(0, 128'h030201, 3, 1, 8);
    repeat (2) @(negedge clk);
    len_in      = 5'd2;
    vocab_count = 5'd0;
    cs_v[0]     = 1'b1;
    @(negedge clk);
    cs_v[0] = 1'b0;
    finish_run(0, "cs_busy", lat);
    extra = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done[0] === 1'b1 || busy[0] === 1'b1) extra++;
    end
    chk("cs_busy_no_restart", 128'(extra), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
